tempo_strobe_generator: RTL and testbench
=========================================

TEMPO_STROBE_GENERATOR -- requirements
Module: tempo_strobe_generator

Interface
REQ-001 SHALL have parameter CLOCKS_PER_TICK, default 416_667, meaning i_clk cycles per tick (25 MHz / 60 Hz); legal range >= 2.
REQ-002 SHALL have parameter BEAT_W, default 4, meaning width of the ticks-per-beat field.
REQ-003 SHALL have parameter BAR_W, default 4, meaning width of the beats-per-bar field.
REQ-004 SHALL have parameter DEFAULT_TICKS_PER_BEAT, default 5, meaning the ticks-per-beat value in force after reset.
REQ-005 SHALL have parameter DEFAULT_BEATS_PER_BAR, default 4, meaning the beats-per-bar value in force after reset.
REQ-006 SHALL have port i_clk, input, 1 bit: sole clock; one clock domain; all logic on the rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_enable, input, 1 bit: counters advance when high and hold when low.
REQ-009 SHALL have port i_restart, input, 1 bit: synchronous realign of all counters to zero.
REQ-010 SHALL have port i_ticks_per_beat, input, BEAT_W bits: requested ticks per beat.
REQ-011 SHALL have port i_beats_per_bar, input, BAR_W bits: requested beats per bar.
REQ-012 SHALL have port o_tick_stb, output, 1 bit: one-cycle pulse per tick.
REQ-013 SHALL have port o_beat_stb, output, 1 bit: one-cycle pulse on the last tick of a beat.
REQ-014 SHALL have port o_bar_stb, output, 1 bit: one-cycle pulse on the last tick of the last beat of a bar.

Function
REQ-015 Clock counter SHALL count 0..CLOCKS_PER_TICK-1, wrap to 0, advance only when i_enable=1, and be $clog2(CLOCKS_PER_TICK) bits wide.
REQ-016 o_tick_stb SHALL be combinational: i_enable & (clock counter == CLOCKS_PER_TICK-1) & !i_restart.
REQ-017 Tick-in-beat counter SHALL advance on o_tick_stb and wrap to 0 after active_tpb-1; o_beat_stb = o_tick_stb & (tick counter == active_tpb-1).
REQ-018 Beat-in-bar counter SHALL advance on o_beat_stb and wrap to 0 after active_bpb-1; o_bar_stb = o_beat_stb & (beat counter == active_bpb-1).
REQ-019 active_tpb and active_bpb SHALL be registers loaded from i_ticks_per_beat / i_beats_per_bar only on o_bar_stb or i_restart; mid-bar input changes SHALL have no effect until then.
REQ-020 A requested value of 0 SHALL be loaded as 1.
REQ-021 i_restart SHALL take priority over i_enable: next cycle all three counters = 0, config loaded, and all strobes low in the restart cycle.
REQ-022 Strobe nesting SHALL hold: o_bar_stb implies o_beat_stb implies o_tick_stb, in the same cycle.
REQ-023 Strobe latency SHALL be zero: pulses are decoded from counter state and never registered.

Reset
REQ-024 On i_rst_n=0, all counters SHALL clear to 0 and active_tpb/active_bpb SHALL take DEFAULT_TICKS_PER_BEAT/DEFAULT_BEATS_PER_BAR, asynchronously.
REQ-025 During reset all strobes SHALL be 0; after release the first tick SHALL occur CLOCKS_PER_TICK enabled cycles later.

Configuration
REQ-026 With TEMPO_POSITION_EN defined, SHALL add outputs o_tick_index [BEAT_W-1:0] and o_beat_index [BAR_W-1:0] = current tick-in-beat and beat-in-bar counters (reset 0).
REQ-027 Without TEMPO_POSITION_EN, those ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package tempo_pkg SHALL hold the default BEAT_W/BAR_W and default tempo constants.
REQ-029 The three counters SHALL each be an instance of sub-module strobe_divider: parametrised width, runtime modulus, advance enable, synchronous clear, and wrap-pulse output.

Verification (CLOCKS_PER_TICK=4, defaults 5/4)
REQ-030 Reset release, i_enable=1 -> o_tick_stb on clocks 4, 8, ...; o_beat_stb on clock 20; o_bar_stb on clock 80, coincident with beat and tick.
REQ-031 i_enable low for 10 cycles mid-tick -> every subsequent strobe shifts exactly 10 cycles; no strobe while low.
REQ-032 i_ticks_per_beat changed 5->2 at clock 30 -> beats stay 20 clocks apart until the bar at clock 80, then beats every 8 clocks.
REQ-033 i_ticks_per_beat=0 with i_restart -> o_beat_stb on every tick; with i_beats_per_bar=0, o_bar_stb also on every tick.
REQ-034 i_restart in the same cycle as a would-be bar strobe -> no strobe that cycle, counters 0, next tick 4 cycles later.
REQ-035 i_rst_n dropped mid-bar between clock edges -> strobes and indices 0 immediately; active config back to 5/4.

Source files
------------

// File: rtl/tempo_pkg.sv
// Shared tempo constants: default field widths and the reset-time tempo.
package tempo_pkg;

    localparam int unsigned DEF_CLOCKS_PER_TICK   = 416_667;
    localparam int unsigned DEF_BEAT_W            = 4;
    localparam int unsigned DEF_BAR_W             = 4;
    localparam int unsigned DEF_TICKS_PER_BEAT    = 5;
    localparam int unsigned DEF_BEATS_PER_BAR     = 4;

endpackage

// File: rtl/strobe_divider.sv
// Wrapping counter with runtime terminal value, advance enable, synchronous
// clear and a wrap pulse; one instance per level of the tempo hierarchy.
module strobe_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == i_last);

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_advance) begin
            count_d = at_last ? '0 : count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_wrap  = i_advance & at_last & ~i_clear;

endmodule

// File: rtl/tempo_strobe_generator.sv
// Tick / beat / bar strobe generator with bar-aligned tempo changes.
// Optional TEMPO_POSITION_EN exposes the tick-in-beat and beat-in-bar position.
module tempo_strobe_generator
    import tempo_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_TICK        = DEF_CLOCKS_PER_TICK,
    parameter int unsigned BEAT_W                 = DEF_BEAT_W,
    parameter int unsigned BAR_W                  = DEF_BAR_W,
    parameter int unsigned DEFAULT_TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
    parameter int unsigned DEFAULT_BEATS_PER_BAR  = DEF_BEATS_PER_BAR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_restart,
    input  logic [BEAT_W-1:0] i_ticks_per_beat,
    input  logic [BAR_W-1:0]  i_beats_per_bar,
    output logic              o_tick_stb,
    output logic              o_beat_stb,
    output logic              o_bar_stb
`ifdef TEMPO_POSITION_EN
    ,
    output logic [BEAT_W-1:0] o_tick_index,
    output logic [BAR_W-1:0]  o_beat_index
`endif
);

    localparam int unsigned       CLK_W    = $clog2(CLOCKS_PER_TICK);
    localparam logic [CLK_W-1:0]  CLK_LAST = CLK_W'(CLOCKS_PER_TICK - 1);

    logic [CLK_W-1:0]  clk_count;
    logic              clk_wrap;
    logic [BEAT_W-1:0] tick_count;
    logic              tick_wrap;
    logic [BAR_W-1:0]  beat_count;
    logic              beat_wrap;

    logic [BEAT_W-1:0] active_tpb_q;
    logic [BEAT_W-1:0] active_tpb_d;
    logic [BAR_W-1:0]  active_bpb_q;
    logic [BAR_W-1:0]  active_bpb_d;
    logic [BEAT_W-1:0] tpb_last;
    logic [BAR_W-1:0]  bpb_last;
    logic              cfg_load;

    assign tpb_last = active_tpb_q - BEAT_W'(1);
    assign bpb_last = active_bpb_q - BAR_W'(1);

    // Strobes are decoded straight from counter state, so they carry no latency.
    assign o_tick_stb = i_enable & ~i_restart & (clk_count == CLK_LAST);
    assign o_beat_stb = o_tick_stb & (tick_count == tpb_last);
    assign o_bar_stb  = o_beat_stb & (beat_count == bpb_last);

    strobe_divider #(.WIDTH(CLK_W)) u_clk_div (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_restart),
        .i_advance (i_enable),
        .i_last    (CLK_LAST),
        .o_count   (clk_count),
        .o_wrap    (clk_wrap)
    );

    strobe_divider #(.WIDTH(BEAT_W)) u_tick_div (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_restart),
        .i_advance (clk_wrap),
        .i_last    (tpb_last),
        .o_count   (tick_count),
        .o_wrap    (tick_wrap)
    );

    strobe_divider #(.WIDTH(BAR_W)) u_beat_div (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_restart),
        .i_advance (tick_wrap),
        .i_last    (bpb_last),
        .o_count   (beat_count),
        .o_wrap    (beat_wrap)
    );

    // The beat divider wraps exactly on the bar strobe: a tempo change lands on a bar edge.
    assign cfg_load = i_restart | beat_wrap;

    always_comb begin
        active_tpb_d = active_tpb_q;
        active_bpb_d = active_bpb_q;
        if (cfg_load) begin
            active_tpb_d = (i_ticks_per_beat == '0) ? BEAT_W'(1) : i_ticks_per_beat;
            active_bpb_d = (i_beats_per_bar == '0) ? BAR_W'(1) : i_beats_per_bar;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_tpb_q <= BEAT_W'(DEFAULT_TICKS_PER_BEAT);
            active_bpb_q <= BAR_W'(DEFAULT_BEATS_PER_BAR);
        end else begin
            active_tpb_q <= active_tpb_d;
            active_bpb_q <= active_bpb_d;
        end
    end

`ifdef TEMPO_POSITION_EN
    assign o_tick_index = tick_count;
    assign o_beat_index = beat_count;
`endif

endmodule

// File: tb/tb_tempo_strobe_generator.sv
// Directed bench for tempo_strobe_generator with CLOCKS_PER_TICK=4, defaults 5/4.
module tb_tempo_strobe_generator;

    localparam int unsigned BEAT_W = 4;
    localparam int unsigned BAR_W  = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_enable;
    logic              i_restart;
    logic [BEAT_W-1:0] i_ticks_per_beat;
    logic [BAR_W-1:0]  i_beats_per_bar;
    logic              o_tick_stb;
    logic              o_beat_stb;
    logic              o_bar_stb;
`ifdef TEMPO_POSITION_EN
    logic [BEAT_W-1:0] o_tick_index;
    logic [BAR_W-1:0]  o_beat_index;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    tempo_strobe_generator #(
        .CLOCKS_PER_TICK        (4),
        .BEAT_W                 (BEAT_W),
        .BAR_W                  (BAR_W),
        .DEFAULT_TICKS_PER_BEAT (5),
        .DEFAULT_BEATS_PER_BAR  (4)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_enable         (i_enable),
        .i_restart        (i_restart),
        .i_ticks_per_beat (i_ticks_per_beat),
        .i_beats_per_bar  (i_beats_per_bar),
        .o_tick_stb       (o_tick_stb),
        .o_beat_stb       (o_beat_stb),
        .o_bar_stb        (o_bar_stb)
`ifdef TEMPO_POSITION_EN
        ,
        .o_tick_index     (o_tick_index),
        .o_beat_index     (o_beat_index)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clock n: strobes sampled on the falling edge before the n-th rising edge.
    task automatic clk_cycle(input string tag, input int k, input bit et, input bit eb, input bit er);
        @(negedge i_clk);
        check($sformatf("%s@%0d {tick,beat,bar}", tag, k),
              {29'd0, o_tick_stb, o_beat_stb, o_bar_stb}, {29'd0, et, eb, er});
        @(posedge i_clk);
        #1;
    endtask

    task automatic restart_cycle(input string tag, input logic [BEAT_W-1:0] tpb,
                                 input logic [BAR_W-1:0] bpb);
        i_ticks_per_beat = tpb;
        i_beats_per_bar  = bpb;
        i_restart        = 1'b1;
        clk_cycle(tag, 0, 1'b0, 1'b0, 1'b0);
        i_restart        = 1'b0;
    endtask

    task automatic run_default(input string tag);
        for (int k = 1; k <= 80; k++)
            clk_cycle(tag, k, (k % 4) == 0, (k % 20) == 0, (k % 80) == 0);
    endtask

    initial begin
        i_rst_n          = 1'b0;
        i_enable         = 1'b1;
        i_restart        = 1'b0;
        i_ticks_per_beat = 4'd5;
        i_beats_per_bar  = 4'd4;

        // Strobes stay low while reset is held, even with enable high.
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            check($sformatf("in_reset@%0d", k), {29'd0, o_tick_stb, o_beat_stb, o_bar_stb}, 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Default tempo: tick every 4, beat every 20, bar every 80.
        run_default("default");

        // Enable low for 10 cycles with the clock counter at 2.
        for (int k = 1; k <= 90; k++) begin
            int j;
            i_enable = !(k >= 3 && k <= 12);
            j = k - 10;
            if (k <= 12)
                clk_cycle("pause", k, 1'b0, 1'b0, 1'b0);
            else
                clk_cycle("pause", k, (j % 4) == 0, (j % 20) == 0, (j % 80) == 0);
        end
        i_enable = 1'b1;

        // Mid-bar change to 2 ticks per beat takes effect only after the bar at 80.
        for (int k = 1; k <= 112; k++) begin
            bit eb;
            if (k == 30) i_ticks_per_beat = 4'd2;
            eb = (k <= 80) ? ((k % 20) == 0) : (((k - 80) % 8) == 0);
            clk_cycle("tpb_change", k, (k % 4) == 0, eb, (k == 80) || (k == 112));
        end

        // Zero ticks per beat is loaded as 1: a beat on every tick.
        restart_cycle("zero_tpb_rst", 4'd0, 4'd4);
        for (int k = 1; k <= 16; k++)
            clk_cycle("zero_tpb", k, (k % 4) == 0, (k % 4) == 0, (k % 16) == 0);

        // Zero beats per bar as well: all three strobes coincide on every tick.
        restart_cycle("zero_bpb_rst", 4'd0, 4'd0);
        for (int k = 1; k <= 8; k++)
            clk_cycle("zero_bpb", k, (k % 4) == 0, (k % 4) == 0, (k % 4) == 0);

        // Restart on the would-be bar strobe suppresses it and realigns to zero.
        restart_cycle("bar_rst_setup", 4'd5, 4'd4);
        for (int k = 1; k <= 79; k++)
            clk_cycle("pre_bar", k, (k % 4) == 0, (k % 20) == 0, 1'b0);
        i_restart = 1'b1;
        clk_cycle("restart_on_bar", 80, 1'b0, 1'b0, 1'b0);
        i_restart = 1'b0;
        for (int k = 1; k <= 8; k++)
            clk_cycle("post_restart", k, (k % 4) == 0, 1'b0, 1'b0);

        // Asynchronous reset mid-bar while strobes are high; config returns to 5/4.
        restart_cycle("async_setup", 4'd2, 4'd2);
        for (int k = 1; k <= 7; k++)
            clk_cycle("async_pre", k, k == 4, 1'b0, 1'b0);
        #1;
        check("async_pre_strobes", {29'd0, o_tick_stb, o_beat_stb, o_bar_stb}, 32'b110);
        i_rst_n = 1'b0;
        #1;
        check("async_in_reset", {29'd0, o_tick_stb, o_beat_stb, o_bar_stb}, 32'd0);
`ifdef TEMPO_POSITION_EN
        check("async_tick_index", {28'd0, o_tick_index}, 32'd0);
        check("async_beat_index", {28'd0, o_beat_index}, 32'd0);
`endif
        #1;
        i_rst_n = 1'b1;
        run_default("after_async");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
